// File: rtl/prbs7_checker.sv
// rtl/prbs7_checker.sv - PRBS7 (x^7+x^6+1) receive checker with lock FSM and error/bit counters
// Self-synchronises on the incoming stream, then flywheels on its own prediction once locked.
module prbs7_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             prbs_i,
    input  logic             valid_i,
    input  logic             clear_i,
    input  logic             resync_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] bit_cnt_o
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state;
    logic [6:0]    sr;
    logic [2:0]    fill;
    logic [MW-1:0] match;
    logic [EW-1:0] consec;

    logic       pred;
    logic       mis;
    logic [6:0] sr_in;
    logic [6:0] sr_pred;

    assign pred    = sr[6] ^ sr[5];
    assign mis     = prbs_i ^ pred;
    assign sr_in   = {sr[5:0], prbs_i};
    assign sr_pred = {sr[5:0], pred};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= SEARCH;
            sr        <= '0;
            fill      <= '0;
            match     <= '0;
            consec    <= '0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
            bit_cnt_o <= '0;
        end else begin
            err_o <= 1'b0;
            if (resync_i) begin
                state    <= SEARCH;
                fill     <= '0;
                match    <= '0;
                consec   <= '0;
                locked_o <= 1'b0;
            end else if (valid_i) begin
                case (state)
                    SEARCH: begin
                        sr <= sr_in;
                        if (fill != 3'd7) fill <= fill + 3'd1;
                        // An all-zero window is a fixed point of the LFSR, so never verify on it.
                        if (fill >= 3'd6 && sr_in != 7'd0) begin
                            state <= VERIFY;
                            match <= '0;
                        end
                    end
                    VERIFY: begin
                        sr <= sr_in;
                        if (mis) begin
                            state <= SEARCH;
                            fill  <= '0;
                            match <= '0;
                        end else if (int'(match) + 1 == LOCK_CNT) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            consec   <= '0;
                        end else begin
                            match <= match + MW'(1);
                        end
                    end
                    LOCKED: begin
                        // Flywheel on the prediction so line errors do not pollute the register.
                        sr <= sr_pred;
                        if (bit_cnt_o != '1) bit_cnt_o <= bit_cnt_o + CNT_W'(1);
                        if (mis) begin
                            err_o <= 1'b1;
                            if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + CNT_W'(1);
                            if (int'(consec) + 1 >= UNLOCK_ERRS) begin
                                state    <= SEARCH;
                                fill     <= '0;
                                match    <= '0;
                                consec   <= '0;
                                locked_o <= 1'b0;
                            end else begin
                                consec <= consec + EW'(1);
                            end
                        end else begin
                            consec <= '0;
                        end
                    end
                    default: begin
                        state    <= SEARCH;
                        fill     <= '0;
                        match    <= '0;
                        consec   <= '0;
                        locked_o <= 1'b0;
                    end
                endcase
            end
            if (clear_i) begin
                err_cnt_o <= '0;
                bit_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// tb/tb_prbs7_checker.sv - self-checking bench for prbs7_checker against a window-queue model
// Two instances (16-bit and 4-bit counters) share one stimulus stream.
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1, prbs = 1'b0, valid = 1'b0, clr = 1'b0, resync = 1'b0;
    logic        locked, err, locked4, err4;
    logic [15:0] err_cnt, bit_cnt;
    logic [3:0]  err_cnt4, bit_cnt4;

    always #5 clk = ~clk;

    prbs7_checker dut (
        .clk_i(clk), .rst_i(rst), .prbs_i(prbs), .valid_i(valid), .clear_i(clr),
        .resync_i(resync), .locked_o(locked), .err_o(err),
        .err_cnt_o(err_cnt), .bit_cnt_o(bit_cnt)
    );

    prbs7_checker #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .prbs_i(prbs), .valid_i(valid), .clear_i(clr),
        .resync_i(resync), .locked_o(locked4), .err_o(err4),
        .err_cnt_o(err_cnt4), .bit_cnt_o(bit_cnt4)
    );

    int checks = 0;
    int errors = 0;

    // Reference: mode is "hunting", "confirming" or "tracking"; win holds the last 7 bits, oldest first.
    int   m_mode, m_fill, m_match, m_consec;
    bit   m_win[$];
    bit   m_locked, m_err;
    int   m_ec16, m_bc16, m_ec4, m_bc4;
    logic [6:0] g;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(int x, int maxv);
        return (x > maxv) ? maxv : x;
    endfunction

    function automatic bit win_nonzero();
        foreach (m_win[i]) if (m_win[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0;
        m_win = '{0, 0, 0, 0, 0, 0, 0};
        m_locked = 0; m_err = 0;
        m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0;
    endtask

    task automatic model_step(bit r, bit v, bit b, bit c, bit rs);
        bit p;
        if (r) begin
            model_reset();
            return;
        end
        m_err = 0;
        p = m_win[0] ^ m_win[1];
        if (rs) begin
            m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0; m_locked = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                void'(m_win.pop_front()); m_win.push_back(b);
                m_fill = sat(m_fill + 1, 7);
                if (m_fill == 7 && win_nonzero()) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                void'(m_win.pop_front()); m_win.push_back(b);
                if (b != p) begin
                    m_mode = 0; m_fill = 0; m_match = 0;
                end else begin
                    m_match++;
                    if (m_match == 16) begin m_mode = 2; m_locked = 1; m_consec = 0; end
                end
            end else begin
                void'(m_win.pop_front()); m_win.push_back(p);
                m_bc16 = sat(m_bc16 + 1, 65535); m_bc4 = sat(m_bc4 + 1, 15);
                if (b != p) begin
                    m_err = 1;
                    m_ec16 = sat(m_ec16 + 1, 65535); m_ec4 = sat(m_ec4 + 1, 15);
                    m_consec++;
                    if (m_consec == 4) begin
                        m_mode = 0; m_fill = 0; m_match = 0; m_consec = 0; m_locked = 0;
                    end
                end else begin
                    m_consec = 0;
                end
            end
        end
        if (c) begin m_ec16 = 0; m_bc16 = 0; m_ec4 = 0; m_bc4 = 0; end
    endtask

    task automatic cyc(bit v, bit b, bit c = 0, bit rs = 0, bit r = 0);
        valid = v; prbs = b; clr = c; resync = rs; rst = r;
        @(posedge clk);
        model_step(r, v, b, c, rs);
        #1;
        check("locked", 32'(locked), 32'(m_locked));
        check("err", 32'(err), 32'(m_err));
        check("err_cnt", 32'(err_cnt), 32'(m_ec16));
        check("bit_cnt", 32'(bit_cnt), 32'(m_bc16));
        check("locked4", 32'(locked4), 32'(m_locked));
        check("err4", 32'(err4), 32'(m_err));
        check("err_cnt4", 32'(err_cnt4), 32'(m_ec4));
        check("bit_cnt4", 32'(bit_cnt4), 32'(m_bc4));
    endtask

    task automatic next_bit(output bit b);
        b = g[6] ^ g[5];
        g = {g[5:0], b};
    endtask

    initial begin
        bit b;
        int n_lock, pulses, nv;
        model_reset();

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        check("rst_locked", 32'(locked), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // Continuous stream from seed 01 locks on the 23rd valid bit.
        g = 7'h01; n_lock = 0;
        for (int n = 1; n <= 40 && n_lock == 0; n++) begin
            next_bit(b); cyc(1, b);
            if (locked === 1'b1) n_lock = n;
        end
        check("lock_bits", 32'(n_lock), 23);
        check("lock_err_cnt", 32'(err_cnt), 0);

        // Single inverted bit: one pulse, stays locked.
        for (int i = 0; i < 10; i++) begin next_bit(b); cyc(1, b); end
        next_bit(b); cyc(1, ~b);
        pulses = int'(err);
        for (int i = 0; i < 20; i++) begin next_bit(b); cyc(1, b); pulses += int'(err); end
        check("single_pulses", 32'(pulses), 1);
        check("single_err_cnt", 32'(err_cnt), 1);
        check("single_locked", 32'(locked), 1);

        // Four consecutive errors drop lock, clean stream relocks after 23 bits.
        cyc(0, 0, 1);
        for (int i = 0; i < 4; i++) begin next_bit(b); cyc(1, ~b); end
        check("burst_err_cnt", 32'(err_cnt), 4);
        check("burst_unlocked", 32'(locked), 0);
        n_lock = 0;
        for (int n = 1; n <= 60 && n_lock == 0; n++) begin
            next_bit(b); cyc(1, b);
            if (locked === 1'b1) n_lock = n;
        end
        check("relock_bits", 32'(n_lock), 23);

        // All-zero input never leaves the hunting state.
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 100; i++) cyc(1, 0);
        check("zeros_locked", 32'(locked), 0);
        check("zeros_err_cnt", 32'(err_cnt), 0);
        check("zeros_bit_cnt", 32'(bit_cnt), 0);

        // 4-bit counter saturation and clear-vs-increment priority.
        cyc(0, 0, 0, 1);
        n_lock = 0;
        for (int n = 1; n <= 60 && n_lock == 0; n++) begin
            next_bit(b); cyc(1, b);
            if (locked4 === 1'b1) n_lock = n;
        end
        check("sat_relock", 32'(n_lock), 23);
        cyc(0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            next_bit(b); cyc(1, ~b);
            for (int k = 0; k < 3; k++) begin next_bit(b); cyc(1, b); end
        end
        check("sat_err_cnt4", 32'(err_cnt4), 15);
        check("sat_err_cnt16", 32'(err_cnt), 20);
        check("sat_locked4", 32'(locked4), 1);
        next_bit(b); cyc(1, ~b, 1);
        check("clr_err_cnt4", 32'(err_cnt4), 0);
        check("clr_err4", 32'(err4), 1);

        // Random 50% valid from seed 5A, then reset while locked.
        cyc(0, 0, 0, 0, 1);
        g = 7'h5A; nv = 0; n_lock = 0;
        for (int n = 0; n < 300 && n_lock == 0; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                next_bit(b); nv++; cyc(1, b);
            end else begin
                cyc(0, $urandom_range(0, 1) == 1);
            end
            if (locked === 1'b1) n_lock = nv;
        end
        check("rand_lock_bits", 32'(n_lock), 23);
        cyc(0, 0, 0, 0, 1);
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_bit_cnt", 32'(bit_cnt), 0);

        // Randomised mix of errors, stalls, clears and resyncs against the model.
        g = 7'h33;
        for (int n = 0; n < 600; n++) begin
            bit v, flip;
            v = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, 15) == 0);
            if (v) next_bit(b); else b = 0;
            cyc(v, b ^ flip, $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
